cache_axi_bridge: RTL and testbench

// - Bridges the icache and dcache miss and writeback interfaces to one AXI3 master port. Sits directly downstream of both caches.
// - Arbitrates reads, drives AR/R bursts for line refills and uncached words, and drives AW/W/B for dcache writebacks and uncached stores.
// - One outstanding read and one outstanding write. Dcache reads to a line that is still being written wait for the write to complete (RAW guard).

---
 rtl/cache_axi_pkg.sv | 44 ++++
 rtl/bridge_wr_channel.sv | 118 +++++++++++
 rtl/cache_axi_bridge.sv | 194 +++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// ============================================================================
// Module : cache_axi_pkg
// Brief  : Shared IDs, request type codes and FSM state types for the
//          cache-to-AXI3 bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_axi_pkg;

    localparam logic [3:0]  ID_ICACHE  = 4'd0;
    localparam logic [3:0]  ID_DCACHE  = 4'd1;
    localparam int unsigned LINE_BEATS = 4;

    localparam logic [2:0] c_type_byte  = 3'b000;
    localparam logic [2:0] c_type_half  = 3'b001;
    localparam logic [2:0] c_type_word  = 3'b010;
    localparam logic [2:0] c_type_line  = 3'b100;
    localparam logic [1:0] c_burst_incr = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    function automatic logic [7:0] axi_len(input logic [2:0] req_type);
        return (req_type == c_type_line) ? 8'(LINE_BEATS - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] axi_size(input logic [2:0] req_type);
        return (req_type == c_type_line) ? 3'd2 : {1'b0, req_type[1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_wr_channel.sv
// ============================================================================
// Module : bridge_wr_channel
// Brief  : Dcache writeback / uncached store engine driving AXI AW, W and B.
//          Exposes busy and the pending line address for the read-side guard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bridge_wr_channel
    import cache_axi_pkg::*;
(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_BEATS-1:0] wr_data,
    output logic                    wr_rdy,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    busy,
    output logic [27:0]             line_addr
);

    localparam int unsigned       c_cnt_w     = $clog2(LINE_BEATS);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(LINE_BEATS - 1);

    wr_state_t                 r_state;
    wr_state_t                 w_next;
    logic [31:0]               r_addr;
    logic [2:0]                r_type;
    logic [3:0]                r_strb;
    logic [32*LINE_BEATS-1:0]  r_data;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      w_is_line;
    logic                      w_last_beat;

    assign w_is_line   = (r_type == c_type_line);
    assign w_last_beat = w_is_line ? (r_cnt == c_last_beat) : 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr <= '0;
            r_type <= '0;
            r_strb <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (r_state == W_IDLE && wr_req) begin
            r_addr <= wr_addr;
            r_type <= wr_type;
            r_strb <= wr_wstrb;
            r_data <= wr_data;
            r_cnt  <= '0;
        end else if (r_state == W_DATA && wready) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        wr_rdy  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        case (r_state)
            W_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) w_next = W_ADDR;
            end
            W_ADDR: begin
                awvalid = 1'b1;
                if (awready) w_next = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = w_last_beat;
                if (w_last_beat && wready) w_next = W_RESP;
            end
            W_RESP: begin
                // Response code is not reported back to the dcache.
                bready = 1'b1;
                if (bvalid) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign awaddr    = r_addr;
    assign awlen     = axi_len(r_type);
    assign awsize    = axi_size(r_type);
    assign wdata     = r_data[32*r_cnt +: 32];
    assign wstrb     = w_is_line ? 4'hf : r_strb;
    assign busy      = (r_state != W_IDLE);
    assign line_addr = r_addr[31:4];

endmodule

`default_nettype wire

// File: rtl/cache_axi_bridge.sv
// ============================================================================
// Module : cache_axi_bridge
// Brief  : Merges icache/dcache refill and writeback traffic onto one AXI3
//          master with one outstanding read and one outstanding write.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_axi_bridge
    import cache_axi_pkg::*;
(
    input  logic                    aclk,
    input  logic                    aresetn,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic                    icache_rd_req,
    input  logic [2:0]              icache_rd_type,
    input  logic [31:0]             icache_rd_addr,
    output logic                    icache_rd_rdy,
    output logic                    icache_ret_valid,
    output logic                    icache_ret_last,
    output logic [31:0]             icache_ret_data,
    input  logic                    dcache_rd_req,
    input  logic [2:0]              dcache_rd_type,
    input  logic [31:0]             dcache_rd_addr,
    output logic                    dcache_rd_rdy,
    output logic                    dcache_ret_valid,
    output logic                    dcache_ret_last,
    output logic [31:0]             dcache_ret_data,
    input  logic                    dcache_wr_req,
    input  logic [2:0]              dcache_wr_type,
    input  logic [31:0]             dcache_wr_addr,
    input  logic [3:0]              dcache_wr_wstrb,
    input  logic [32*LINE_BEATS-1:0] dcache_wr_data,
    output logic                    dcache_wr_rdy
);

    rd_state_t   r_rd_state;
    rd_state_t   w_rd_next;
    logic [31:0] r_rd_addr;
    logic [2:0]  r_rd_type;
    logic [3:0]  r_rd_id;
    logic        w_wr_busy;
    logic [27:0] w_wr_line;
    logic        w_raw_hit;
    logic        w_rd_idle;
    logic        w_dc_acc;
    logic        w_ic_acc;
    logic        w_r_active;
    logic        w_unused_ok;

    assign w_unused_ok = ^{rresp, bid, bresp};

    // A dcache read must not overtake a pending write to the same line.
    assign w_raw_hit = w_wr_busy && (dcache_rd_addr[31:4] == w_wr_line);
    assign w_rd_idle = (r_rd_state == R_IDLE);
    assign w_dc_acc  = w_rd_idle && dcache_rd_req && !w_raw_hit;
    assign w_ic_acc  = w_rd_idle && icache_rd_req && (!dcache_rd_req || w_raw_hit);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_addr <= '0;
            r_rd_type <= '0;
            r_rd_id   <= '0;
        end else if (w_dc_acc) begin
            r_rd_addr <= dcache_rd_addr;
            r_rd_type <= dcache_rd_type;
            r_rd_id   <= ID_DCACHE;
        end else if (w_ic_acc) begin
            r_rd_addr <= icache_rd_addr;
            r_rd_type <= icache_rd_type;
            r_rd_id   <= ID_ICACHE;
        end
    end

    always_comb begin
        w_rd_next     = r_rd_state;
        dcache_rd_rdy = 1'b0;
        icache_rd_rdy = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                dcache_rd_rdy = !w_raw_hit;
                icache_rd_rdy = !dcache_rd_req || w_raw_hit;
                if (w_dc_acc || w_ic_acc) w_rd_next = R_AR;
            end
            R_AR: begin
                arvalid = 1'b1;
                if (arready) w_rd_next = R_DATA;
            end
            R_DATA: begin
                // Beats with an unknown rid are still acknowledged and dropped.
                rready = 1'b1;
                if (rvalid && rlast) w_rd_next = R_IDLE;
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

    assign arid    = r_rd_id;
    assign araddr  = r_rd_addr;
    assign arlen   = axi_len(r_rd_type);
    assign arsize  = axi_size(r_rd_type);
    assign arburst = c_burst_incr;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign w_r_active       = (r_rd_state == R_DATA) && rvalid;
    assign icache_ret_valid = w_r_active && (rid == ID_ICACHE);
    assign dcache_ret_valid = w_r_active && (rid == ID_DCACHE);
    assign icache_ret_last  = rlast;
    assign dcache_ret_last  = rlast;
    assign icache_ret_data  = rdata;
    assign dcache_ret_data  = rdata;

    assign awid    = ID_DCACHE;
    assign wid     = ID_DCACHE;
    assign awburst = c_burst_incr;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    bridge_wr_channel u_wr_channel (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_req    (dcache_wr_req),
        .wr_type   (dcache_wr_type),
        .wr_addr   (dcache_wr_addr),
        .wr_wstrb  (dcache_wr_wstrb),
        .wr_data   (dcache_wr_data),
        .wr_rdy    (dcache_wr_rdy),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .busy      (w_wr_busy),
        .line_addr (w_wr_line)
    );

endmodule

`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
// ============================================================================
// Module : tb_cache_axi_bridge
// Brief  : Scoreboard bench for cache_axi_bridge acting as cache and AXI slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_axi_bridge;
    import cache_axi_pkg::*;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic         icache_rd_req;
    logic [2:0]   icache_rd_type;
    logic [31:0]  icache_rd_addr;
    logic         icache_rd_rdy;
    logic         icache_ret_valid;
    logic         icache_ret_last;
    logic [31:0]  icache_ret_data;
    logic         dcache_rd_req;
    logic [2:0]   dcache_rd_type;
    logic [31:0]  dcache_rd_addr;
    logic         dcache_rd_rdy;
    logic         dcache_ret_valid;
    logic         dcache_ret_last;
    logic [31:0]  dcache_ret_data;
    logic         dcache_wr_req;
    logic [2:0]   dcache_wr_type;
    logic [31:0]  dcache_wr_addr;
    logic [3:0]   dcache_wr_wstrb;
    logic [127:0] dcache_wr_data;
    logic         dcache_wr_rdy;

    always #5 aclk = ~aclk;

    cache_axi_bridge dut (
        .aclk (aclk), .aresetn (aresetn),
        .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
        .arburst (arburst), .arlock (arlock), .arcache (arcache), .arprot (arprot),
        .arvalid (arvalid), .arready (arready),
        .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast),
        .rvalid (rvalid), .rready (rready),
        .awid (awid), .awaddr (awaddr), .awlen (awlen), .awsize (awsize),
        .awburst (awburst), .awlock (awlock), .awcache (awcache), .awprot (awprot),
        .awvalid (awvalid), .awready (awready),
        .wid (wid), .wdata (wdata), .wstrb (wstrb), .wlast (wlast),
        .wvalid (wvalid), .wready (wready),
        .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready),
        .icache_rd_req (icache_rd_req), .icache_rd_type (icache_rd_type),
        .icache_rd_addr (icache_rd_addr), .icache_rd_rdy (icache_rd_rdy),
        .icache_ret_valid (icache_ret_valid), .icache_ret_last (icache_ret_last),
        .icache_ret_data (icache_ret_data),
        .dcache_rd_req (dcache_rd_req), .dcache_rd_type (dcache_rd_type),
        .dcache_rd_addr (dcache_rd_addr), .dcache_rd_rdy (dcache_rd_rdy),
        .dcache_ret_valid (dcache_ret_valid), .dcache_ret_last (dcache_ret_last),
        .dcache_ret_data (dcache_ret_data),
        .dcache_wr_req (dcache_wr_req), .dcache_wr_type (dcache_wr_type),
        .dcache_wr_addr (dcache_wr_addr), .dcache_wr_wstrb (dcache_wr_wstrb),
        .dcache_wr_data (dcache_wr_data), .dcache_wr_rdy (dcache_wr_rdy)
    );

    // dest: 0 = icache, 1 = dcache, 2 = dropped
    typedef struct {
        logic [1:0]  dest;
        logic [31:0] data;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
    } a_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_exp_t;

    r_exp_t r_q[$];
    a_exp_t ar_q[$];
    a_exp_t aw_q[$];
    w_exp_t w_q[$];
    r_exp_t mon_r;
    a_exp_t mon_a;
    w_exp_t mon_w;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] base, input int idx);
        return base ^ 32'h5a5a_0000 ^ (32'(idx) * 32'h0101_0101);
    endfunction

    always @(negedge aclk) begin
        if (aresetn) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    check("ar_unexpected", 1, 0);
                end else begin
                    mon_a = ar_q.pop_front();
                    check("araddr", araddr, mon_a.addr);
                    check("arlen", arlen, mon_a.len);
                    check("arsize", arsize, mon_a.size);
                    check("arid", arid, mon_a.id);
                    check("ar_const", {arburst, arlock, arcache, arprot}, {2'b01, 2'b00, 4'h0, 3'h0});
                end
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    mon_r = r_q.pop_front();
                    check("ic_ret_valid", icache_ret_valid, mon_r.dest == 2'd0);
                    check("dc_ret_valid", dcache_ret_valid, mon_r.dest == 2'd1);
                    if (mon_r.dest == 2'd0) begin
                        check("ic_ret_data", icache_ret_data, mon_r.data);
                        check("ic_ret_last", icache_ret_last, mon_r.last);
                    end
                    if (mon_r.dest == 2'd1) begin
                        check("dc_ret_data", dcache_ret_data, mon_r.data);
                        check("dc_ret_last", dcache_ret_last, mon_r.last);
                    end
                end
            end
            if (awvalid && awready) begin
                if (aw_q.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    mon_a = aw_q.pop_front();
                    check("awaddr", awaddr, mon_a.addr);
                    check("awlen", awlen, mon_a.len);
                    check("awsize", awsize, mon_a.size);
                    check("awid", awid, mon_a.id);
                    check("aw_const", {awburst, awlock, awcache, awprot}, {2'b01, 2'b00, 4'h0, 3'h0});
                end
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    mon_w = w_q.pop_front();
                    check("wdata", wdata, mon_w.data);
                    check("wstrb", wstrb, mon_w.strb);
                    check("wlast", wlast, mon_w.last);
                    check("wid", wid, ID_DCACHE);
                end
            end
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic ar_handshake;
        for (int i = 0; i < 20 && !arvalid; i++) tick();
        if (!arvalid) check("arvalid_timeout", 0, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic aw_handshake;
        for (int i = 0; i < 20 && !awvalid; i++) tick();
        if (!awvalid) check("awvalid_timeout", 0, 1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
    endtask

    task automatic w_beats(input int n);
        wready = 1'b1;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 20 && !wvalid; i++) tick();
            if (!wvalid) check("wvalid_timeout", 0, 1);
            tick();
        end
        wready = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [1:0] dest,
                          input logic [31:0] data, input logic last);
        rid    = id;
        rdata  = data;
        rlast  = last;
        rvalid = 1'b1;
        r_q.push_back('{dest: dest, data: data, last: last});
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic r_burst(input logic [3:0] id, input logic [1:0] dest,
                           input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) r_beat(id, dest, mem_word(base, i), i == n - 1);
    endtask

    task automatic write_issue(input logic [31:0] addr, input logic [2:0] typ,
                               input logic [3:0] strb, input logic [127:0] data);
        int n;
        n = (typ == c_type_line) ? 4 : 1;
        dcache_wr_req   = 1'b1;
        dcache_wr_type  = typ;
        dcache_wr_addr  = addr;
        dcache_wr_wstrb = strb;
        dcache_wr_data  = data;
        aw_q.push_back('{addr: addr, len: 8'(n - 1),
                         size: (typ == c_type_line) ? 3'd2 : {1'b0, typ[1:0]}, id: ID_DCACHE});
        for (int i = 0; i < n; i++)
            w_q.push_back('{data: data[32*i +: 32],
                            strb: (typ == c_type_line) ? 4'hf : strb, last: i == n - 1});
        #1;
        check("wr_rdy_idle", dcache_wr_rdy, 1);
        tick();
        dcache_wr_req = 1'b0;
        check("wr_rdy_busy", dcache_wr_rdy, 0);
    endtask

    task automatic b_handshake;
        check("wr_rdy_wresp", dcache_wr_rdy, 0);
        check("bready", bready, 1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("wr_rdy_after_b", dcache_wr_rdy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        icache_rd_req = 0; icache_rd_type = 0; icache_rd_addr = 0;
        dcache_rd_req = 0; dcache_rd_type = 0; dcache_rd_addr = 0;
        dcache_wr_req = 0; dcache_wr_type = 0; dcache_wr_addr = 0;
        dcache_wr_wstrb = 0; dcache_wr_data = 0;

        #12;
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready,
                             icache_ret_valid, dcache_ret_valid, wlast}, 8'h00);
        check("rst_araddr", araddr, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        tick();
        aresetn = 1'b1;
        tick();

        // Icache line refill
        icache_rd_req  = 1'b1;
        icache_rd_type = c_type_line;
        icache_rd_addr = 32'h1c00_0000;
        ar_q.push_back('{addr: 32'h1c00_0000, len: 8'd3, size: 3'd2, id: ID_ICACHE});
        #1;
        check("t1_ic_rdy", icache_rd_rdy, 1);
        tick();
        icache_rd_req = 1'b0;
        check("t1_arvalid_next", arvalid, 1);
        ar_handshake();
        r_burst(ID_ICACHE, 2'd0, 32'h1c00_0000, 4);
        check("t1_back_idle", icache_rd_rdy, 1);

        // Simultaneous word reads: dcache wins
        dcache_rd_req  = 1'b1;
        dcache_rd_type = c_type_word;
        dcache_rd_addr = 32'h0000_2004;
        icache_rd_req  = 1'b1;
        icache_rd_type = c_type_word;
        icache_rd_addr = 32'h0000_1000;
        ar_q.push_back('{addr: 32'h0000_2004, len: 8'd0, size: 3'd2, id: ID_DCACHE});
        ar_q.push_back('{addr: 32'h0000_1000, len: 8'd0, size: 3'd2, id: ID_ICACHE});
        #1;
        check("t2_dc_rdy", dcache_rd_rdy, 1);
        check("t2_ic_blocked", icache_rd_rdy, 0);
        tick();
        dcache_rd_req = 1'b0;
        ar_handshake();
        check("t2_ic_wait", icache_rd_rdy, 0);
        r_burst(ID_DCACHE, 2'd1, 32'h0000_2004, 1);
        check("t2_ic_after_rlast", icache_rd_rdy, 1);
        tick();
        icache_rd_req = 1'b0;
        ar_handshake();
        r_burst(ID_ICACHE, 2'd0, 32'h0000_1000, 1);

        // Beat with unknown rid is dropped
        dcache_rd_req  = 1'b1;
        dcache_rd_addr = 32'h0000_3000;
        ar_q.push_back('{addr: 32'h0000_3000, len: 8'd0, size: 3'd2, id: ID_DCACHE});
        tick();
        dcache_rd_req = 1'b0;
        ar_handshake();
        r_beat(4'd7, 2'd2, 32'hdead_beef, 1'b0);
        r_beat(ID_DCACHE, 2'd1, mem_word(32'h0000_3000, 0), 1'b1);

        // Dcache line writeback
        write_issue(32'h0000_0080, c_type_line, 4'h0,
                    128'h00004444_00003333_00002222_00001111);
        aw_handshake();
        check("t3_wr_rdy_wdata", dcache_wr_rdy, 0);
        w_beats(4);
        b_handshake();

        // Uncached byte store
        write_issue(32'h0000_0302, c_type_byte, 4'b0100, 128'h0000_0000_0000_0000_0000_0000_00ab_0000);
        aw_handshake();
        w_beats(1);
        b_handshake();

        // RAW guard with a concurrent different-line read
        write_issue(32'h0000_0100, c_type_line, 4'h0,
                    128'h0d0d0d0d_0c0c0c0c_0b0b0b0b_0a0a0a0a);
        dcache_rd_req  = 1'b1;
        dcache_rd_type = c_type_word;
        dcache_rd_addr = 32'h0000_0200;
        ar_q.push_back('{addr: 32'h0000_0200, len: 8'd0, size: 3'd2, id: ID_DCACHE});
        #1;
        check("t5_diff_line_rdy", dcache_rd_rdy, 1);
        tick();
        dcache_rd_req = 1'b0;
        ar_handshake();
        r_burst(ID_DCACHE, 2'd1, 32'h0000_0200, 1);
        dcache_rd_req  = 1'b1;
        dcache_rd_addr = 32'h0000_0108;
        #1;
        check("t5_raw_stall", dcache_rd_rdy, 0);
        check("t5_raw_ic_rdy", icache_rd_rdy, 1);
        aw_handshake();
        check("t5_stall_wdata", dcache_rd_rdy, 0);
        w_beats(4);
        check("t5_stall_wresp", dcache_rd_rdy, 0);
        b_handshake();
        check("t5_raw_release", dcache_rd_rdy, 1);
        ar_q.push_back('{addr: 32'h0000_0108, len: 8'd0, size: 3'd2, id: ID_DCACHE});
        tick();
        dcache_rd_req = 1'b0;
        ar_handshake();
        r_burst(ID_DCACHE, 2'd1, 32'h0000_0108, 1);

        // Reset during the second refill beat
        icache_rd_req  = 1'b1;
        icache_rd_type = c_type_line;
        icache_rd_addr = 32'h0000_0040;
        ar_q.push_back('{addr: 32'h0000_0040, len: 8'd3, size: 3'd2, id: ID_ICACHE});
        tick();
        icache_rd_req = 1'b0;
        ar_handshake();
        r_beat(ID_ICACHE, 2'd0, mem_word(32'h0000_0040, 0), 1'b0);
        rid     = ID_ICACHE;
        rdata   = mem_word(32'h0000_0040, 1);
        rvalid  = 1'b1;
        aresetn = 1'b0;
        #1;
        check("t6_rst_valids", {arvalid, rready, awvalid, wvalid, bready,
                                icache_ret_valid, dcache_ret_valid}, 7'h00);
        rvalid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        check("t6_rd_idle", dcache_rd_rdy, 1);
        check("t6_wr_idle", dcache_wr_rdy, 1);
        dcache_rd_req  = 1'b1;
        dcache_rd_type = c_type_word;
        dcache_rd_addr = 32'h0000_0044;
        ar_q.push_back('{addr: 32'h0000_0044, len: 8'd0, size: 3'd2, id: ID_DCACHE});
        tick();
        dcache_rd_req = 1'b0;
        ar_handshake();
        r_burst(ID_DCACHE, 2'd1, 32'h0000_0044, 1);
        check("t6_idle_again", dcache_rd_rdy, 1);

        tick();
        check("r_q_empty", r_q.size(), 0);
        check("ar_q_empty", ar_q.size(), 0);
        check("aw_q_empty", aw_q.size(), 0);
        check("w_q_empty", w_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
